pll_lock_supervisor: RTL

//  Controller on the other side of the PLL wrapper's LOCK/RESET pins: drives the PLL RESET input and consumes its LOCK output.

---
 rtl/pll_lock_supervisor.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: resets the PLL, waits for lock with timeout and bounded retries,
// releases system reset after stable lock. Optional lock-loss counter under PLL_SUP_LOSS_CNT_EN.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock_i,
  output logic       pll_reset_o,
  output logic       sys_resetn_o,
  output logic       locked_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o
`ifdef PLL_SUP_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt_o,
  input  logic       loss_clr_i
`endif
);

  localparam int MAXC_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAXC    = (MAXC_AB > LOCK_STABLE_CYCLES) ? MAXC_AB : LOCK_STABLE_CYCLES;
  localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_sync1;
  logic            r_lock_s;
  logic [3:0]      r_retry;
  logic [RW-1:0]   r_fail;
  logic            r_pll_reset;
  logic            r_sys_resetn;
  logic            r_locked;
  logic            r_fault;
  logic            w_retry_inc;
  logic            w_loss_evt;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_lock_i;
      r_lock_s <= r_sync1;
    end
  end

  // Next-state logic; fail count is compared before it is incremented
  always_comb begin
    w_next      = r_state;
    w_retry_inc = 1'b0;
    w_loss_evt  = 1'b0;
    case (r_state)
      ST_RST_PLL: begin
        if (r_cnt == RST_LAST) begin
          w_next = ST_WAIT_LOCK;
        end else begin
          w_next = ST_RST_PLL;
        end
      end
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_next = ST_STABLE;
        end else if (r_cnt == TO_LAST) begin
          w_retry_inc = 1'b1;
          if (r_fail == RETRY_LIM) begin
            w_next = ST_FAULT;
          end else begin
            w_next = ST_RST_PLL;
          end
        end else begin
          w_next = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!r_lock_s) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_cnt == STB_LAST) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_STABLE;
        end
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_next     = ST_RST_PLL;
          w_loss_evt = 1'b1;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_FAULT: begin
        w_next = ST_FAULT;
      end
      default: begin
        w_next = ST_RST_PLL;
      end
    endcase
  end

  // State, shared cycle counter and retry bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_RST_PLL;
      r_cnt   <= '0;
      r_retry <= 4'd0;
      r_fail  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_retry_inc && (r_retry != 4'hF)) begin
        r_retry <= r_retry + 4'd1;
      end
      if (w_retry_inc) begin
        r_fail <= r_fail + RW'(1);
      end
    end
  end

  // Outputs registered from the next state so they change together with the state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pll_reset  <= 1'b1;
      r_sys_resetn <= 1'b0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_pll_reset  <= (w_next == ST_RST_PLL) || (w_next == ST_FAULT);
      r_sys_resetn <= (w_next == ST_RUN);
      r_locked     <= (w_next == ST_RUN);
      r_fault      <= (w_next == ST_FAULT);
    end
  end

  assign pll_reset_o  = r_pll_reset;
  assign sys_resetn_o = r_sys_resetn;
  assign locked_o     = r_locked;
  assign fault_o      = r_fault;
  assign retry_cnt_o  = r_retry;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;

  // Lock-loss counter; a clear takes priority over a coincident loss
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_loss_cnt <= 8'd0;
    end else if (loss_clr_i) begin
      r_loss_cnt <= 8'd0;
    end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end else begin
      r_loss_cnt <= r_loss_cnt;
    end
  end

  assign loss_cnt_o = r_loss_cnt;
`else
  logic w_loss_unused;
  assign w_loss_unused = w_loss_evt;
`endif

endmodule
